// File: rtl/wgen_pkg.sv
// -----------------------------------------------------------------------------
// wgen_pkg
// Shared definitions for the write-side traffic generator (wdata_gen).
//   state_e  : FSM state encoding (IDLE, GEN, CHECK, WRITE, DONE)
//   MODE_*   : run-time filter mode codes
// -----------------------------------------------------------------------------
package wgen_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGen   = 3'd1,
        StCheck = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_ALL  = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_EVEN = 2'b10;

endpackage

// File: rtl/wgen_filter.sv
// -----------------------------------------------------------------------------
// wgen_filter
// Combinational word filter: decides whether a generated word may be written.
// Ports:
//   wdata [DW-1:0] in  : candidate word
//   mode  [1:0]    in  : MODE_ALL / MODE_ODD / MODE_EVEN (2'b11 behaves as ALL)
//   pass           out : 1 when the word is accepted
// -----------------------------------------------------------------------------
module wgen_filter
    import wgen_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    mode,
    output logic          pass
);

    logic parity;

    always_comb begin
        parity = ^wdata;
        case (mode)
            MODE_ODD:  pass = parity;
            MODE_EVEN: pass = ~parity;
            default:   pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/wdata_gen.sv
// -----------------------------------------------------------------------------
// wdata_gen
// Write-side traffic generator for the async-FIFO harness (wclk domain).
// Generates an incrementing sequence, filters each word by parity mode and
// pushes accepted words into the FIFO under wfull back-pressure.
// Ports:
//   wclk, wrst_n          : clock, asynchronous active-low reset
//   start                 : 1-cycle pulse, starts a burst from IDLE
//   stop                  : abort request (level), honoured outside WRITE
//   mode [1:0]            : filter mode, latched at start
//   burst_len [BURST_W-1:0]: words per burst, 0 = continuous; latched at start
//   wfull                 : FIFO full flag
//   winc, wdata           : registered FIFO write strobe / data
//   wcount                : words written in the current burst
//   busy                  : 1 while not IDLE
//   done                  : 1-cycle pulse at burst completion or abort
//   skip_cnt [15:0]       : only with WGEN_SKIP_CNT_EN defined; filter rejects
//                           in the current burst, saturating
// Configuration macro: WGEN_SKIP_CNT_EN
// -----------------------------------------------------------------------------
module wdata_gen
    import wgen_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned STEP    = 1,
    parameter int unsigned BURST_W = 8
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               wfull,
    output logic               winc,
    output logic [DW-1:0]      wdata,
    output logic [BURST_W-1:0] wcount,
    output logic               busy,
    output logic               done
`ifdef WGEN_SKIP_CNT_EN
    ,
    output logic [15:0]        skip_cnt
`endif
);

    localparam logic [DW-1:0] StepW = DW'(STEP);

    state_e             state_q, state_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [BURST_W-1:0] wcount_q, wcount_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic               winc_q, winc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass;
    logic               last_word;
    logic               burst_start;

    wgen_filter #(
        .DW (DW)
    ) u_filter (
        .wdata (wdata_q),
        .mode  (mode_q),
        .pass  (pass)
    );

    assign burst_start = (state_q == StIdle) && start;
    // Burst length 0 never matches, giving continuous mode.
    assign last_word   = (len_q != '0) && ((wcount_q + BURST_W'(1)) == len_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StGen;
            StGen:   state_d = stop ? StDone : StCheck;
            StCheck: begin
                if (stop) begin
                    state_d = StDone;
                end else if (!pass) begin
                    state_d = StGen;
                end else if (!wfull) begin
                    state_d = StWrite;
                end
            end
            // stop is deliberately not sampled here; it acts in the next GEN.
            StWrite: state_d = last_word ? StDone : StGen;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs decoded from next state ----------------
    always_comb begin
        winc_d = (state_d == StWrite);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        wdata_d  = wdata_q;
        wcount_d = wcount_q;
        len_d    = len_q;
        mode_d   = mode_q;
        if (burst_start) begin
            wcount_d = '0;
            len_d    = burst_len;
            mode_d   = mode;
        end
        if ((state_q == StGen) && !stop) begin
            wdata_d = wdata_q + StepW;
        end
        if (state_q == StWrite) begin
            wcount_d = wcount_q + BURST_W'(1);
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wdata_q  <= '0;
            wcount_q <= '0;
            len_q    <= '0;
            mode_q   <= MODE_ALL;
            winc_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wdata_q  <= wdata_d;
            wcount_q <= wcount_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            winc_q   <= winc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign winc   = winc_q;
    assign wdata  = wdata_q;
    assign wcount = wcount_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef WGEN_SKIP_CNT_EN
    logic [15:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (burst_start) begin
            skip_cnt_d = '0;
        end else if ((state_q == StCheck) && !stop && !pass && (skip_cnt_q != 16'hFFFF)) begin
            skip_cnt_d = skip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_wdata_gen.sv
// -----------------------------------------------------------------------------
// tb_wdata_gen
// Scoreboard bench for wdata_gen: dut0 (DW=16) and dut1 (DW=4, wrap test).
// Expected write words are queued when a burst is issued; a forked monitor pops
// and compares on every winc.
// -----------------------------------------------------------------------------
module tb_wdata_gen;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    logic        start0, stop0, wfull0;
    logic [1:0]  mode0;
    logic [7:0]  len0;
    logic        winc0, busy0, done0;
    logic [15:0] wdata0;
    logic [7:0]  wcount0;

    logic        start1, stop1, wfull1;
    logic [1:0]  mode1;
    logic [7:0]  len1;
    logic        winc1, busy1, done1;
    logic [3:0]  wdata1;
    logic [7:0]  wcount1;

`ifdef WGEN_SKIP_CNT_EN
    logic [15:0] skip0, skip1;
`endif

    wdata_gen #(.DW(16), .STEP(1), .BURST_W(8)) dut0 (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .start     (start0),
        .stop      (stop0),
        .mode      (mode0),
        .burst_len (len0),
        .wfull     (wfull0),
        .winc      (winc0),
        .wdata     (wdata0),
        .wcount    (wcount0),
        .busy      (busy0),
        .done      (done0)
`ifdef WGEN_SKIP_CNT_EN
        ,
        .skip_cnt  (skip0)
`endif
    );

    wdata_gen #(.DW(4), .STEP(1), .BURST_W(8)) dut1 (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .start     (start1),
        .stop      (stop1),
        .mode      (mode1),
        .burst_len (len1),
        .wfull     (wfull1),
        .winc      (winc1),
        .wdata     (wdata1),
        .wcount    (wcount1),
        .busy      (busy1),
        .done      (done1)
`ifdef WGEN_SKIP_CNT_EN
        ,
        .skip_cnt  (skip1)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] q0[$];
    logic [3:0]  q1[$];
    logic [15:0] exp0;
    logic [3:0]  exp1;
    int          w1_cnt = 0;
    bit          done1_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wclk);
    endtask

    // Called at a negedge; returns at the following negedge with start low.
    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge wclk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge wclk);
            if (done0 === 1'b1) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b0;
        start0 = 0; stop0 = 0; wfull0 = 0; mode0 = 2'b00; len0 = 8'd0;
        start1 = 0; stop1 = 0; wfull1 = 0; mode1 = 2'b00; len1 = 8'd0;

        // Monitor: compares every presented write against the scoreboard.
        fork
            forever begin
                @(negedge wclk);
                if (winc0 === 1'b1) begin
                    if (q0.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dut0 unexpected write: got 0x%0h, expected none", wdata0);
                    end else begin
                        exp0 = q0.pop_front();
                        check("dut0 wdata", 32'(wdata0), 32'(exp0));
                    end
                end
                if (winc1 === 1'b1) begin
                    w1_cnt++;
                    if (q1.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dut1 unexpected write: got 0x%0h, expected none", wdata1);
                    end else begin
                        exp1 = q1.pop_front();
                        check("dut1 wdata", 32'(wdata1), 32'(exp1));
                    end
                end
                if (done1 === 1'b1) done1_seen = 1'b1;
            end
        join_none

        // Reset state
        tick(3);
        check("rst winc", 32'(winc0), 32'd0);
        check("rst wdata", 32'(wdata0), 32'd0);
        check("rst wcount", 32'(wcount0), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst dut1 wdata", 32'(wdata1), 32'd0);
        wrst_n = 1'b1;
        tick(1);

        // Test 1: odd parity, 4 words -> 1,2,4,7; start->winc latency is 2 edges
        mode0 = 2'b01; len0 = 8'd4;
        q0.push_back(16'h0001); q0.push_back(16'h0002);
        q0.push_back(16'h0004); q0.push_back(16'h0007);
        pulse_start0();
        check("t1 busy after start", 32'(busy0), 32'd1);
        @(negedge wclk);
        check("t1 winc not early", 32'(winc0), 32'd0);
        @(negedge wclk);
        check("t1 winc latency", 32'(winc0), 32'd1);
        wait_done0("t1 done seen", 100);
        check("t1 wcount", 32'(wcount0), 32'd4);
`ifdef WGEN_SKIP_CNT_EN
        check("t1 skip_cnt", 32'(skip0), 32'd3);
`endif
        tick(1);
        check("t1 done one cycle", 32'(done0), 32'd0);
        check("t1 busy idle", 32'(busy0), 32'd0);
        check("t1 queue drained", 32'(q0.size()), 32'd0);

        // Test 2: even parity, 3 words -> 9,A,C; mid-burst input changes ignored
        mode0 = 2'b10; len0 = 8'd3;
        q0.push_back(16'h0009); q0.push_back(16'h000A); q0.push_back(16'h000C);
        pulse_start0();
        mode0 = 2'b00; len0 = 8'd0;
        wait_done0("t2 done seen", 100);
        check("t2 wcount", 32'(wcount0), 32'd3);
`ifdef WGEN_SKIP_CNT_EN
        check("t2 skip_cnt", 32'(skip0), 32'd2);
`endif
        tick(1);
        check("t2 queue drained", 32'(q0.size()), 32'd0);

        // Test 3: wfull held in CHECK freezes the word; release writes next edge
        mode0 = 2'b00; len0 = 8'd2; wfull0 = 1'b1;
        q0.push_back(16'h000D); q0.push_back(16'h000E);
        pulse_start0();
        for (int i = 0; i < 10; i++) begin
            @(negedge wclk);
            check("t3 winc held low", 32'(winc0), 32'd0);
            check("t3 wdata frozen", 32'(wdata0), 32'h000D);
        end
        wfull0 = 1'b0;
        @(negedge wclk);
        check("t3 write after release", 32'(winc0), 32'd1);
        wait_done0("t3 done seen", 50);
        check("t3 wcount", 32'(wcount0), 32'd2);
        tick(1);
        check("t3 queue drained", 32'(q0.size()), 32'd0);

        // Test 4: DW=4 continuous, 17 writes wrap 1..15,0,1; stop ends it
        mode1 = 2'b00; len1 = 8'd0;
        for (int i = 1; i <= 17; i++) q1.push_back(4'(i));
        start1 = 1'b1;
        @(negedge wclk);
        start1 = 1'b0;
        for (int i = 0; i < 200 && w1_cnt < 17; i++) begin
            @(negedge wclk);
            #1;
        end
        check("t4 write count", 32'(w1_cnt), 32'd17);
        stop1 = 1'b1;
        check("t4 no done before stop", 32'(done1_seen), 32'd0);
        for (int i = 0; i < 10 && !done1_seen; i++) begin
            @(negedge wclk);
            #1;
        end
        check("t4 done after stop", 32'(done1_seen), 32'd1);
        stop1 = 1'b0;
        check("t4 wcount", 32'(wcount1), 32'd17);
        tick(1);
        check("t4 busy idle", 32'(busy1), 32'd0);
        check("t4 queue drained", 32'(q1.size()), 32'd0);

        // Test 5: reset while waiting in CHECK, just as wfull releases
        mode0 = 2'b00; len0 = 8'd1; wfull0 = 1'b1;
        pulse_start0();
        tick(2);
        check("t5 holding word", 32'(wdata0), 32'h000F);
        wfull0 = 1'b0;
        wrst_n = 1'b0;
        #1;
        check("t5 winc in reset", 32'(winc0), 32'd0);
        check("t5 wdata in reset", 32'(wdata0), 32'd0);
        check("t5 busy in reset", 32'(busy0), 32'd0);
        check("t5 wcount in reset", 32'(wcount0), 32'd0);
        @(negedge wclk);
        check("t5 no write", 32'(winc0), 32'd0);
        wrst_n = 1'b1;
        tick(1);

        // Sequence restarts from zero after reset
        mode0 = 2'b01; len0 = 8'd1;
        q0.push_back(16'h0001);
        pulse_start0();
        wait_done0("t5b done seen", 50);
        check("t5b wcount", 32'(wcount0), 32'd1);
`ifdef WGEN_SKIP_CNT_EN
        check("t5b skip_cnt", 32'(skip0), 32'd0);
`endif
        tick(2);
        check("final q0 drained", 32'(q0.size()), 32'd0);
        check("final q1 drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
